uart_rx_axis: RTL and testbench
===============================

Name: uart_rx_axis

Overview:
Second-generation UART receiver for the serial ingress path. It replaces the fixed-rate receiver with the following features:
- runtime baud divisor
- configurable data width, parity and stop bits
- 2-FF input synchroniser
- 3-sample majority vote
- false-start rejection, framing, break and overrun detection

Received characters are presented on an AXI-Stream master with a one-entry holding register, ready for a downstream FIFO/bridge.

Parameters:
DATA_BITS, 8, character width; legal 5..9.
PARITY, "even", "none" | "even" | "odd".
STOP_BITS, 1, stop bits checked; legal 1 or 2.
DIV_W, 16, width of baud_div input and bit counter.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
rx  input  1  asynchronous serial line, idle high.
baud_div  input  DIV_W  clk cycles per bit; latched at start-bit detect; values <8 treated as 8.
m_axis_tdata  output  DATA_BITS  received character, LSB = first bit on the line.
m_axis_tvalid  output  1  character held and valid.
m_axis_tready  input  1  downstream accept.
m_axis_tuser  output  2  {framing_error, parity_error} for the held character.
parity_error  output  1  1-clk pulse on parity mismatch.
framing_error  output  1  1-clk pulse on a zero stop bit (non-break).
overrun  output  1  1-clk pulse when a completed character is dropped.
break_det  output  1  1-clk pulse on break condition.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; sync flops 1; counters 0. Reset mid-frame aborts the frame with no output.
- Synchroniser: rx passes through 2 flops (rx_s); all logic uses rx_s, adding 2 clk input latency.
- Bit timing:
  - Counter cnt runs 0..div-1 per bit; mid = div>>1.
  - rx_s is sampled at cnt = mid-1, mid, mid+1; bit value = majority of the 3 samples.
  - The bit boundary is cnt == div-1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- IDLE:
  - On rx_s == 0: latch div = max(baud_div, 8), cnt = 0, go to START.
  - Otherwise stay.
- START:
  - At cnt == mid+1, majority == 1 is a false start: return to IDLE, no pulses, no output.
  - Otherwise at cnt == div-1 go to DATA with bit index 0.
- DATA: shift in DATA_BITS bits LSB first. After the last bit go to PARITY, or to STOP if PARITY == "none".
- PARITY:
  - Even: error if XOR(data, pbit) != 0.
  - Odd: error if XOR(data, pbit) != 1.
- STOP:
  - Each of STOP_BITS bits is voted; any 0 sets a framing error.
  - The frame completes at cnt == mid+1 of the last stop bit, and the FSM returns to IDLE in the same cycle (half-bit early, tolerating clock mismatch).
- Break:
  - Condition: all data bits 0, parity bit 0 (if present) and first stop bit 0.
  - Action: break_det pulses; no character is delivered; no framing_error or parity_error pulses.
  - Go to BRK_WAIT, which stays until rx_s == 1, then IDLE.
- Delivery (completion cycle C, non-break):
  - If the holding register is free, or m_axis_tvalid && m_axis_tready in cycle C: load tdata and tuser, tvalid = 1 at C+1.
  - Else: drop the new character, pulse overrun, keep the held character unchanged.
  - Error pulses parity_error/framing_error assert at C+1 regardless of drop.
- Stream protocol:
  - tvalid stays high, and tdata/tuser stay stable, until the tready handshake.
  - tvalid clears the cycle after a handshake unless a new load coincides.
- Frames with parity or framing errors are still delivered, flagged in tuser.
- baud_div changes mid-frame have no effect until the next start bit.

Test Plan:
1. baud_div=16, 8E1, send 0xA5 with pbit 0, stop 1, tready=1 -> tdata=0xA5, tuser=00, tvalid for 1 clk, no pulses.
2. baud_div=16, send 0x3C with pbit 1 (wrong for even) -> tdata=0x3C, tuser=01, parity_error pulse; repeat with stop bit 0 -> tuser=10, framing_error pulse.
3. Glitch rx low for 5 clks with baud_div=16 -> no output, FSM back in IDLE; a following valid 0x55 frame is received correctly.
4. tready=0, send 0x11 then 0x22 -> tdata holds 0x11, overrun pulses once at completion of 0x22; raise tready -> 0x11 accepted, tvalid drops.
5. Hold rx low for 30 bit times -> exactly one break_det pulse, no tvalid; after rx returns high, 0x7E is received normally.
6. PARITY="none", DATA_BITS=7, STOP_BITS=2, baud_div=434, send 0x41; then assert rst mid-frame -> 0x41 delivered; the aborted frame produces nothing and outputs read 0.

Source files
------------

// File: rtl/uart_rx_axis.sv
// uart_rx_axis: oversampled UART receiver with majority vote, error/break detection
// and a one-entry AXI-Stream holding register.
module uart_rx_axis #(
  parameter int    DATA_BITS = 8,
  parameter string PARITY    = "even",
  parameter int    STOP_BITS = 1,
  parameter int    DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [DIV_W-1:0]     baud_div,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [1:0]           m_axis_tuser,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 break_det
);
  localparam bit   HAS_PAR = PARITY != "none";
  localparam logic ODD     = PARITY == "odd";
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;
  state_t               state_q, state_d;
  logic                 rx_m_q, rx_s_q;
  logic [DIV_W-1:0]     div_q, div_d, cnt_q, cnt_d, mid;
  logic [3:0]           bit_q, bit_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] data_q, data_d, tdata_q, tdata_d;
  logic                 pz_q, pz_d, perr_q, perr_d, ferr_q, ferr_d;
  logic [1:0]           tuser_q, tuser_d;
  logic                 tvalid_q, tvalid_d, pe_q, pe_d, fe_q, fe_d, ov_q, ov_d, brk_q, brk_d;
  logic                 last, at_m1, at_m, at_p1, maj, brk_hit, ferr_n;
  assign mid     = div_q >> 1;
  assign last    = cnt_q == div_q - DIV_W'(1);
  assign at_m1   = cnt_q == mid - DIV_W'(1);
  assign at_m    = cnt_q == mid;
  assign at_p1   = cnt_q == mid + DIV_W'(1);
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  // break needs an all-zero character, zero parity bit and a zero first stop bit
  assign brk_hit = bit_q == 4'd0 && data_q == '0 && (!HAS_PAR || pz_q) && !maj;
  assign ferr_n  = ferr_q | !maj;
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = last ? '0 : cnt_q + DIV_W'(1);
    bit_d    = bit_q;
    samp_d   = samp_q;
    data_d   = data_q;
    pz_d     = pz_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tvalid_d = tvalid_q && !m_axis_tready;
    pe_d     = 1'b0;
    fe_d     = 1'b0;
    ov_d     = 1'b0;
    brk_d    = 1'b0;
    if (at_m1) samp_d[0] = rx_s_q;
    if (at_m) samp_d[1] = rx_s_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
          div_d   = baud_div < DIV_W'(8) ? DIV_W'(8) : baud_div;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (at_p1 && maj) state_d = S_IDLE;
        else if (last) begin
          state_d = S_DATA;
          bit_d   = 4'd0;
        end
      end
      S_DATA: begin
        if (at_p1) data_d = {maj, data_q[DATA_BITS-1:1]};
        if (last) begin
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            state_d = HAS_PAR ? S_PAR : S_STOP;
            bit_d   = 4'd0;
          end
        end
      end
      S_PAR: begin
        if (at_p1) begin
          perr_d = ^data_q ^ maj ^ ODD;
          pz_d   = !maj;
        end
        if (last) state_d = S_STOP;
      end
      S_STOP: begin
        if (at_p1) begin
          if (brk_hit) begin
            brk_d   = 1'b1;
            state_d = S_BRK;
          end else begin
            ferr_d = ferr_n;
            // completes half a bit early to tolerate clock mismatch
            if (bit_q == 4'(STOP_BITS - 1)) begin
              state_d = S_IDLE;
              pe_d    = perr_q;
              fe_d    = ferr_n;
              if (!tvalid_q || m_axis_tready) begin
                tvalid_d = 1'b1;
                tdata_d  = data_q;
                tuser_d  = {ferr_n, perr_q};
              end else ov_d = 1'b1;
            end
          end
        end else if (last) bit_d = bit_q + 4'd1;
      end
      S_BRK: if (rx_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rx_m_q   <= 1'b1;
      rx_s_q   <= 1'b1;
      div_q    <= DIV_W'(8);
      cnt_q    <= '0;
      bit_q    <= '0;
      samp_q   <= '1;
      data_q   <= '0;
      pz_q     <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= '0;
      tvalid_q <= 1'b0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      ov_q     <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rx_m_q   <= rx;
      rx_s_q   <= rx_m_q;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      samp_q   <= samp_d;
      data_q   <= data_d;
      pz_q     <= pz_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tvalid_q <= tvalid_d;
      pe_q     <= pe_d;
      fe_q     <= fe_d;
      ov_q     <= ov_d;
      brk_q    <= brk_d;
    end
  end
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tuser  = tuser_q;
  assign parity_error  = pe_q;
  assign framing_error = fe_q;
  assign overrun       = ov_q;
  assign break_det     = brk_q;
endmodule

// File: tb/tb_uart_rx_axis.sv
// tb_uart_rx_axis: directed scenarios on an 8E1 receiver and a 7N2 receiver.
module tb_uart_rx_axis;
  logic        clk = 0, rst = 1, rx = 1, tready = 1;
  logic [15:0] div = 16;
  logic [7:0]  tdata;
  logic [1:0]  tuser;
  logic        tvalid, pe, fe, ov, brk;
  logic        rst2 = 1, rx2 = 1, tready2 = 1;
  logic [15:0] div2 = 434;
  logic [6:0]  tdata2;
  logic [1:0]  tuser2;
  logic        tvalid2, pe2, fe2, ov2, brk2;
  int checks = 0, errors = 0;
  int hs = 0, vcyc = 0, npe = 0, nfe = 0, nov = 0, nbrk = 0, hs2 = 0, ev2 = 0;
  logic [7:0] ld = 0;
  logic [1:0] lu = 0;
  logic [6:0] ld2 = 0;
  logic [1:0] lu2 = 0;

  uart_rx_axis #(.DATA_BITS(8), .PARITY("even"), .STOP_BITS(1), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .baud_div(div), .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tuser(tuser),
    .parity_error(pe), .framing_error(fe), .overrun(ov), .break_det(brk));

  uart_rx_axis #(.DATA_BITS(7), .PARITY("none"), .STOP_BITS(2), .DIV_W(16)) dut2 (
    .clk(clk), .rst(rst2), .rx(rx2), .baud_div(div2), .m_axis_tdata(tdata2),
    .m_axis_tvalid(tvalid2), .m_axis_tready(tready2), .m_axis_tuser(tuser2),
    .parity_error(pe2), .framing_error(fe2), .overrun(ov2), .break_det(brk2));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tvalid && tready) begin hs++; ld = tdata; lu = tuser; end
    if (tvalid) vcyc++;
    if (pe) npe++;
    if (fe) nfe++;
    if (ov) nov++;
    if (brk) nbrk++;
    if (tvalid2 && tready2) begin hs2++; ld2 = tdata2; lu2 = tuser2; end
    if (pe2 || fe2 || ov2 || brk2) ev2++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [7:0] d, input logic pb, input logic sb);
    rx = 0; tick(16);
    for (int i = 0; i < 8; i++) begin rx = d[i]; tick(16); end
    rx = pb; tick(16);
    rx = sb; tick(16);
    rx = 1; tick(32);
  endtask

  task automatic send2(input logic [6:0] d);
    rx2 = 0; tick(434);
    for (int i = 0; i < 7; i++) begin rx2 = d[i]; tick(434); end
    rx2 = 1; tick(868 + 434);
  endtask

  task automatic test_reset;
    tick(3);
    checks++; if (tdata !== 8'h00 || tvalid !== 1'b0 || tuser !== 2'b00) begin errors++; $display("FAIL reset_axis got data=%h valid=%b user=%b exp 00/0/00", tdata, tvalid, tuser); end
    checks++; if ({pe, fe, ov, brk} !== 4'b0000) begin errors++; $display("FAIL reset_pulses got %b exp 0000", {pe, fe, ov, brk}); end
    checks++; if (tdata2 !== 7'h00 || tvalid2 !== 1'b0 || {pe2, fe2, ov2, brk2} !== 4'b0) begin errors++; $display("FAIL reset_dut2 got data=%h valid=%b exp 0", tdata2, tvalid2); end
    rst = 0; rst2 = 0;
    tick(5);
  endtask

  task automatic test_basic;
    int h0, v0, e0;
    h0 = hs; v0 = vcyc; e0 = npe + nfe + nov + nbrk;
    send1(8'hA5, 1'b0, 1'b1);
    checks++; if (hs - h0 != 1) begin errors++; $display("FAIL basic_count got %0d exp 1", hs - h0); end
    checks++; if (ld !== 8'hA5 || lu !== 2'b00) begin errors++; $display("FAIL basic_data got %h/%b exp a5/00", ld, lu); end
    checks++; if (vcyc - v0 != 1) begin errors++; $display("FAIL basic_valid_len got %0d exp 1", vcyc - v0); end
    checks++; if (npe + nfe + nov + nbrk - e0 != 0) begin errors++; $display("FAIL basic_pulses got %0d exp 0", npe + nfe + nov + nbrk - e0); end
  endtask

  task automatic test_errors;
    int h0, p0, f0;
    h0 = hs; p0 = npe; f0 = nfe;
    send1(8'h3C, 1'b1, 1'b1);
    checks++; if (hs - h0 != 1 || ld !== 8'h3C || lu !== 2'b01) begin errors++; $display("FAIL parity_deliver got n=%0d %h/%b exp 1 3c/01", hs - h0, ld, lu); end
    checks++; if (npe - p0 != 1 || nfe - f0 != 0) begin errors++; $display("FAIL parity_pulse got pe=%0d fe=%0d exp 1/0", npe - p0, nfe - f0); end
    h0 = hs; p0 = npe; f0 = nfe;
    send1(8'h3C, 1'b0, 1'b0);
    checks++; if (hs - h0 != 1 || ld !== 8'h3C || lu !== 2'b10) begin errors++; $display("FAIL framing_deliver got n=%0d %h/%b exp 1 3c/10", hs - h0, ld, lu); end
    checks++; if (npe - p0 != 0 || nfe - f0 != 1) begin errors++; $display("FAIL framing_pulse got pe=%0d fe=%0d exp 0/1", npe - p0, nfe - f0); end
  endtask

  task automatic test_glitch;
    int h0, e0;
    h0 = hs; e0 = npe + nfe + nov + nbrk;
    rx = 0; tick(5);
    rx = 1; tick(40);
    checks++; if (hs - h0 != 0 || npe + nfe + nov + nbrk - e0 != 0) begin errors++; $display("FAIL glitch_quiet got hs=%0d ev=%0d exp 0/0", hs - h0, npe + nfe + nov + nbrk - e0); end
    send1(8'h55, 1'b0, 1'b1);
    checks++; if (hs - h0 != 1 || ld !== 8'h55 || lu !== 2'b00) begin errors++; $display("FAIL glitch_next got n=%0d %h/%b exp 1 55/00", hs - h0, ld, lu); end
  endtask

  task automatic test_overrun;
    int h0, o0;
    h0 = hs; o0 = nov;
    tready = 0;
    send1(8'h11, 1'b0, 1'b1);
    send1(8'h22, 1'b0, 1'b1);
    checks++; if (tvalid !== 1'b1 || tdata !== 8'h11) begin errors++; $display("FAIL overrun_hold got valid=%b data=%h exp 1/11", tvalid, tdata); end
    checks++; if (nov - o0 != 1 || hs - h0 != 0) begin errors++; $display("FAIL overrun_pulse got ov=%0d hs=%0d exp 1/0", nov - o0, hs - h0); end
    tready = 1;
    tick(2);
    checks++; if (tvalid !== 1'b0 || hs - h0 != 1 || ld !== 8'h11) begin errors++; $display("FAIL overrun_drain got valid=%b n=%0d data=%h exp 0/1/11", tvalid, hs - h0, ld); end
  endtask

  task automatic test_break;
    int h0, b0, e0;
    h0 = hs; b0 = nbrk; e0 = npe + nfe;
    rx = 0; tick(480);
    checks++; if (nbrk - b0 != 1) begin errors++; $display("FAIL break_pulse got %0d exp 1", nbrk - b0); end
    checks++; if (hs - h0 != 0 || tvalid !== 1'b0 || npe + nfe - e0 != 0) begin errors++; $display("FAIL break_quiet got hs=%0d valid=%b err=%0d exp 0/0/0", hs - h0, tvalid, npe + nfe - e0); end
    rx = 1; tick(32);
    send1(8'h7E, 1'b0, 1'b1);
    checks++; if (hs - h0 != 1 || ld !== 8'h7E || lu !== 2'b00 || nbrk - b0 != 1) begin errors++; $display("FAIL break_next got n=%0d %h/%b brk=%0d exp 1 7e/00 1", hs - h0, ld, lu, nbrk - b0); end
  endtask

  task automatic test_cfg2;
    int h0;
    h0 = hs2;
    send2(7'h41);
    checks++; if (hs2 - h0 != 1 || ld2 !== 7'h41 || lu2 !== 2'b00) begin errors++; $display("FAIL cfg2_deliver got n=%0d %h/%b exp 1 41/00", hs2 - h0, ld2, lu2); end
    checks++; if (ev2 != 0) begin errors++; $display("FAIL cfg2_pulses got %0d exp 0", ev2); end
    rx2 = 0; tick(434 * 3);
    rst2 = 1; rx2 = 1; tick(3);
    checks++; if (tdata2 !== 7'h00 || tvalid2 !== 1'b0 || tuser2 !== 2'b00) begin errors++; $display("FAIL cfg2_rst got %h/%b/%b exp 00/0/00", tdata2, tvalid2, tuser2); end
    rst2 = 0; tick(434 * 12);
    checks++; if (hs2 - h0 != 1 || ev2 != 0 || tvalid2 !== 1'b0) begin errors++; $display("FAIL cfg2_abort got n=%0d ev=%0d valid=%b exp 1/0/0", hs2 - h0, ev2, tvalid2); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_errors;
    test_glitch;
    test_overrun;
    test_break;
    test_cfg2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
